// File: rtl/dino_pkg.sv
// Shared types and defaults for the runner-game motion/control block.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        HOLD,
        FALL
    } jump_state_t;

    localparam int unsigned DEF_ANIM_DIV    = 10_000_000;
    localparam int unsigned DEF_JUMP_DIV    = 250_000;
    localparam int unsigned DEF_JUMP_HEIGHT = 100;
    localparam int unsigned DEF_APEX_HOLD   = 8;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned RAND_W = 5;

    localparam logic [LFSR_W-1:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/dino_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), immune to reset.
// Define DINO_RNG_BUTTON_MIX_EN to XOR the button level into the feedback bit.
module dino_lfsr
    import dino_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
    input  logic              clk,
    input  logic              button,
    output logic [LFSR_W-1:0] lfsr_q
);

    // Power-up value only; deliberately untouched by reset so sequences stay varied.
    logic [LFSR_W-1:0] lfsr_r = SEED;
    logic              fb;
    logic [LFSR_W-1:0] lfsr_nxt;

`ifdef DINO_RNG_BUTTON_MIX_EN
    always_comb begin
        fb       = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10] ^ button;
        lfsr_nxt = {lfsr_r[LFSR_W-2:0], fb};
        if (lfsr_nxt == '0) begin
            lfsr_nxt = SEED;
        end
    end
`else
    logic unused_button;
    assign unused_button = button;

    always_comb begin
        fb       = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
        lfsr_nxt = {lfsr_r[LFSR_W-2:0], fb};
        if (lfsr_nxt == '0) begin
            lfsr_nxt = SEED;
        end
    end
`endif

    always_ff @(posedge clk) begin
        lfsr_r <= lfsr_nxt;
    end

    assign lfsr_q = lfsr_r;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Runner-game motion block: run-frame toggle, jump height FSM and random source.
// Optional macro DINO_RNG_BUTTON_MIX_EN (in dino_lfsr) mixes button into the RNG.
module dino_motion_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned       ANIM_DIV    = DEF_ANIM_DIV,
    parameter int unsigned       JUMP_DIV    = DEF_JUMP_DIV,
    parameter int unsigned       JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int unsigned       APEX_HOLD   = DEF_APEX_HOLD,
    parameter logic [LFSR_W-1:0] SEED        = DEF_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              halt,
    output logic              sprite,
    output logic [6:0]        jumpaddr,
    output logic              airborne,
    output logic [RAND_W-1:0] random
);

    localparam int unsigned AW        = $clog2(ANIM_DIV);
    localparam int unsigned SW        = $clog2(JUMP_DIV + 1);
    localparam int unsigned HW        = $clog2(APEX_HOLD + 2);
    localparam int unsigned HOLD_LAST = (APEX_HOLD == 0) ? 0 : APEX_HOLD - 1;

    logic [AW-1:0]     anim_cnt;
    logic [SW-1:0]     step_cnt;
    logic [HW-1:0]     hold_cnt;
    jump_state_t       state;
    logic              tick;
    logic [LFSR_W-1:0] lfsr_q;
    logic              unused_lfsr_hi;

    dino_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk   (clk),
        .button(button),
        .lfsr_q(lfsr_q)
    );

    assign random         = lfsr_q[RAND_W-1:0];
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:RAND_W];
    assign tick           = (step_cnt == SW'(JUMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            anim_cnt <= '0;
            sprite   <= 1'b0;
            state    <= IDLE;
            step_cnt <= '0;
            hold_cnt <= '0;
            jumpaddr <= '0;
            airborne <= 1'b0;
        end else if (!halt) begin
            if (anim_cnt == AW'(ANIM_DIV - 1)) begin
                anim_cnt <= '0;
                sprite   <= ~sprite;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end

            // Every in-flight transition lands on a tick, so the wrap clears the counter on entry.
            if (state == IDLE || tick) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (button) begin
                        state    <= RISE;
                        airborne <= 1'b1;
                    end
                end
                RISE: begin
                    if (tick) begin
                        jumpaddr <= jumpaddr + 7'd1;
                        if (jumpaddr == 7'(JUMP_HEIGHT - 1)) begin
                            state    <= (APEX_HOLD == 0) ? FALL : HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HW'(HOLD_LAST)) begin
                            state <= FALL;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                FALL: begin
                    if (tick) begin
                        jumpaddr <= jumpaddr - 7'd1;
                        if (jumpaddr == 7'd1) begin
                            state    <= IDLE;
                            airborne <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed + randomized bench for dino_motion_ctrl against a jump-profile reference model.
module tb_dino_motion_ctrl;

    localparam int AD    = 4;
    localparam int JD    = 2;
    localparam int JH    = 5;
    localparam int AH    = 2;
    localparam int TOTAL = (2 * JH + AH) * JD;
    localparam logic [15:0] SEED_V = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button = 1'b0;
    logic       halt = 1'b0;
    logic       sprite;
    logic [6:0] jumpaddr;
    logic       airborne;
    logic [4:0] random;

    always #5 clk = ~clk;

    dino_motion_ctrl #(
        .ANIM_DIV   (AD),
        .JUMP_DIV   (JD),
        .JUMP_HEIGHT(JH),
        .APEX_HOLD  (AH),
        .SEED       (SEED_V)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .button  (button),
        .halt    (halt),
        .sprite  (sprite),
        .jumpaddr(jumpaddr),
        .airborne(airborne),
        .random  (random)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: active cycles since reset, and active cycles since jump start.
    int          m_anim = 0;
    bit          m_air = 1'b0;
    int          m_k = 0;
    logic [15:0] m_lfsr = SEED_V;

    function automatic int profile(int k);
        if (k < JH * JD) return k / JD;
        if (k < (JH + AH) * JD) return JH;
        return JH - (k - (JH + AH) * JD) / JD;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit b, bit h, bit r);
        logic        fbit;
        logic [15:0] nxt;
        button = b;
        halt   = h;
        reset  = r;
        @(posedge clk);
        #1;
        fbit = ^(m_lfsr & 16'hB400);
`ifdef DINO_RNG_BUTTON_MIX_EN
        fbit = fbit ^ b;
`endif
        nxt = {m_lfsr[14:0], fbit};
        if (nxt == 16'h0000) nxt = SEED_V;
        m_lfsr = nxt;
        if (r) begin
            m_anim = 0;
            m_air  = 1'b0;
            m_k    = 0;
        end else if (!h) begin
            m_anim++;
            if (m_air) begin
                m_k++;
                if (m_k == TOTAL) m_air = 1'b0;
            end else if (b) begin
                m_air = 1'b1;
                m_k   = 0;
            end
        end
        chk("sprite", 16'(sprite), 16'((m_anim / AD) % 2));
        chk("jumpaddr", 16'(jumpaddr), 16'(m_air ? profile(m_k) : 0));
        chk("airborne", 16'(airborne), 16'(m_air));
        chk("random", 16'(random), 16'(m_lfsr[4:0]));
    endtask

    initial begin
        int          n;
        int          air_cnt;
        int          gap;
        logic [15:0] want;
        bit          rb, rh, rr;

        repeat (3) step(0, 0, 1);
        repeat (16) step(0, 0, 0);

        // Single-cycle button pulse: whole jump airborne for TOTAL cycles.
        step(1, 0, 0);
        air_cnt = (airborne === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0);
            if (airborne === 1'b1) air_cnt++;
        end
        chk("air_len", 16'(air_cnt), 16'(TOTAL));

        // Halt mid-rise at height 3.
        step(1, 0, 0);
        n = 0;
        while (jumpaddr !== 7'd3 && n < 20) begin
            step(0, 0, 0);
            n++;
        end
        chk("reach3", 16'(jumpaddr), 16'd3);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            chk("halt_ja", 16'(jumpaddr), 16'd3);
        end
        repeat (40) step(0, 0, 0);

        // Reset while holding at the apex.
        step(1, 0, 0);
        n = 0;
        while (!(m_air && m_k >= JH * JD && m_k < (JH + AH) * JD) && n < 40) begin
            step(0, 0, 0);
            n++;
        end
        chk("apex", 16'(jumpaddr), 16'(JH));
        step(0, 0, 1);
        chk("rst_ja", 16'(jumpaddr), 16'd0);
        chk("rst_air", 16'(airborne), 16'd0);
        chk("rst_sprite", 16'(sprite), 16'd0);

        // Held button: back-to-back jumps separated by a single grounded cycle.
        gap = 0;
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 0);
            if (airborne === 1'b0) begin
                gap++;
            end else begin
                if (gap > 0) chk("idle_gap", 16'(gap), 16'd1);
                gap = 0;
            end
        end
        step(1, 1, 1);
        chk("rst_over_halt", 16'(airborne), 16'd0);
        step(0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            rh = ($urandom_range(0, 9) == 0);
            rb = ($urandom_range(0, 7) == 0);
            step(rb, rh, rr);
        end

`ifdef DINO_RNG_BUTTON_MIX_EN
        // Steer the register to 16'h8000, then cancel feedback so the zero guard reloads.
        for (int i = 0; i < 16; i++) begin
            want = (i == 0) ? 16'h0001 : 16'h0000;
            step(want[0] ^ (^(m_lfsr & 16'hB400)), 0, 0);
        end
        chk("steer", m_lfsr, 16'h8000);
        step(1, 0, 0);
        want = SEED_V;
        chk("zero_reload", 16'(random), 16'(want[4:0]));
        repeat (20) step(0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
